rotate_arbiter: RTL and testbench

//  Shares one 32-bit combinational rotate datapath between NREQ requesters.

---
 rtl/rot_pkg.sv | 31 +++
 rtl/rotate_arbiter_barrel.sv | 21 ++
 rtl/rotate_arbiter.sv | 110 +++++++++++
 tb/tb_rotate_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared constants and round-robin pick helper for the rotate arbiter.
package rot_pkg;

  localparam int unsigned ROT_W     = 32;
  localparam int unsigned AMT_W     = 5;
  localparam logic        DIR_RIGHT = 1'b1;
  localparam logic        DIR_LEFT  = 1'b0;
  localparam int unsigned MAX_REQ   = 4;

  // First asserted valid bit at or above ptr, wrapping within nreq requesters.
  function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [1:0]         ptr,
                                         input int unsigned        nreq);
    logic [1:0]  g;
    logic        found;
    int unsigned idx;
    logic [1:0]  idx2;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx  = (32'(ptr) + i) % nreq;
      idx2 = idx[1:0];
      if (!found && (i < nreq) && valid[idx2]) begin
        g     = idx2;
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rotate_arbiter_barrel.sv
// Combinational 32-bit circular rotator; left rotations are mapped onto right ones.
module barrelShift32
  import rot_pkg::*;
(
  input  logic [ROT_W-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             dir_i,
  output logic [ROT_W-1:0] data_o
);

  logic [AMT_W-1:0]   rsh;
  logic [2*ROT_W-1:0] dbl;
  logic [2*ROT_W-1:0] shifted;

  // Left by k equals right by (32-k) mod 32.
  assign rsh     = (dir_i == DIR_RIGHT) ? amt_i : (AMT_W'(0) - amt_i);
  assign dbl     = {data_i, data_i};
  assign shifted = dbl >> rsh;
  assign data_o  = shifted[ROT_W-1:0];

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one rotator among NREQ requesters with a registered response.
module rotate_arbiter
  import rot_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1,
  parameter int unsigned CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ROT_W-1:0] req_data,
  input  logic [NREQ*AMT_W-1:0] req_amt,
  input  logic [NREQ-1:0]       req_dir,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ROT_W-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic [CNTW-1:0]       done_cnt
);

  logic [MAX_REQ-1:0] valid_pad;
  logic [1:0]         grant;
  logic               any_valid;
  logic               can_accept;
  logic               accept;
  logic [ROT_W-1:0]   mux_data;
  logic [AMT_W-1:0]   mux_amt;
  logic               mux_dir;
  logic [ROT_W-1:0]   rot_out;

  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ROT_W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [CNTW-1:0]    done_cnt_q, done_cnt_d;

  always_comb begin
    valid_pad             = '0;
    valid_pad[NREQ-1:0]   = req_valid;
  end

  assign any_valid  = |req_valid;
  assign grant      = rr_pick(valid_pad, rr_ptr_q, NREQ);
  assign can_accept = !rsp_valid_q || rsp_ready;
  assign accept     = can_accept && any_valid;

  always_comb begin
    mux_data  = '0;
    mux_amt   = '0;
    mux_dir   = DIR_LEFT;
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == 2'(i)) begin
        mux_data     = req_data[ROT_W*i +: ROT_W];
        mux_amt      = req_amt[AMT_W*i +: AMT_W];
        mux_dir      = req_dir[i];
        req_ready[i] = accept;
      end
    end
  end

  barrelShift32 u_rot (
    .data_i (mux_data),
    .amt_i  (mux_amt),
    .dir_i  (mux_dir),
    .data_o (rot_out)
  );

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    done_cnt_d  = done_cnt_q;
    if (accept) begin
      // A new result may replace one draining in the same cycle.
      rsp_valid_d = 1'b1;
      rsp_data_d  = rot_out;
      rsp_id_d    = IDW'(grant);
      rr_ptr_d    = (grant == 2'(NREQ - 1)) ? 2'd0 : grant + 2'd1;
      done_cnt_d  = done_cnt_q + CNTW'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Self-checking bench for rotate_arbiter (NREQ=2) against a behavioural reference model.
module tb_rotate_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int CNTW = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*5-1:0] req_amt;
  logic [NREQ-1:0]   req_dir;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic [CNTW-1:0]   done_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_id;
  logic [15:0] m_cnt;
  int          m_ptr;
  logic        n_valid;
  logic [31:0] n_data;
  int          n_id;
  logic [15:0] n_cnt;
  int          n_ptr;
  logic [NREQ-1:0] exp_ready;

  rotate_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rot(input logic [31:0] d, input int k, input logic right);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      if (right) r[i] = d[(i + k) % 32];
      else       r[(i + k) % 32] = d[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_id = 0; m_cnt = '0; m_ptr = 0;
  endtask

  // Computes expected ready from current inputs and the next model state.
  task automatic predict();
    int  g;
    bit  found;
    bit  can;
    found = 0; g = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(m_ptr + k) % NREQ]) begin
        g = (m_ptr + k) % NREQ;
        found = 1;
      end
    end
    can = !m_valid || rsp_ready;
    exp_ready = '0;
    n_valid = m_valid; n_data = m_data; n_id = m_id; n_cnt = m_cnt; n_ptr = m_ptr;
    if (found && can) begin
      exp_ready[g] = 1'b1;
      n_valid = 1'b1;
      n_data  = ref_rot(req_data[32*g +: 32], int'(req_amt[5*g +: 5]), req_dir[g]);
      n_id    = g;
      n_cnt   = m_cnt + 16'd1;
      n_ptr   = (g + 1) % NREQ;
    end else if (m_valid && rsp_ready) begin
      n_valid = 1'b0;
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
    m_valid = n_valid; m_data = n_data; m_id = n_id; m_cnt = n_cnt; m_ptr = n_ptr;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] d,
                         input logic [4:0] a, input logic r);
    req_valid[i]        = v;
    req_data[32*i +: 32] = d;
    req_amt[5*i +: 5]    = a;
    req_dir[i]           = r;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_data = '0; req_amt = '0; req_dir = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_data, 32'(rsp_id), done_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%0b data=%h id=%0d cnt=%0d, required all zero",
               rsp_valid, rsp_data, rsp_id, done_cnt);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    logic [31:0] dv [6] = '{32'h8000_0001, 32'h1234_5678, 32'h1234_5678,
                            32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [4:0]  av [6] = '{5'd1, 5'd4, 5'd0, 5'd16, 5'd16, 5'd31};
    logic        rv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int          iv [6] = '{0, 1, 1, 0, 1, 0};
    logic [31:0] xv [6] = '{32'h0000_0003, 32'h8123_4567, 32'h1234_5678,
                            32'hBEEF_DEAD, 32'hBEEF_DEAD, 32'hEF56_DF77};
    for (int t = 0; t < 6; t++) begin
      idle();
      set_req(iv[t], 1'b1, dv[t], av[t], rv[t]);
      #1;
      tick();
      idle();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== xv[t] || int'(rsp_id) != iv[t]
          || rsp_data !== m_data) begin
        errors++;
        $display("FAIL basic[%0d]: valid=%0b data=%h id=%0d, required 1 %h %0d",
                 t, rsp_valid, rsp_data, rsp_id, xv[t], iv[t]);
      end
      checks++;
      if (done_cnt !== m_cnt) begin
        errors++;
        $display("FAIL basic_cnt[%0d]: done_cnt=%0d, required %0d", t, done_cnt, m_cnt);
      end
    end
    tick();
  endtask

  task automatic test_fairness();
    int seq [4] = '{0, 1, 0, 1};
    rst_n = 1'b0; #1; rst_n = 1'b1; model_reset(); #1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(0, 1'b1, $urandom, 5'($urandom), 1'($urandom));
      set_req(1, 1'b1, $urandom, 5'($urandom), 1'($urandom));
      #1;
      checks++;
      if (req_ready !== (2'b01 << seq[t])) begin
        errors++;
        $display("FAIL fair_ready[%0d]: req_ready=%b, required %b", t, req_ready,
                 2'b01 << seq[t]);
      end
      tick();
      checks++;
      if (int'(rsp_id) != seq[t] || rsp_data !== m_data) begin
        errors++;
        $display("FAIL fair_id[%0d]: id=%0d data=%h, required %0d %h", t, rsp_id,
                 rsp_data, seq[t], m_data);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 32'hA5A5_0F0F, 5'd8, 1'b1);
    #1;
    tick();
    held = rsp_data;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'h0000_00FF, 5'd4, 1'b0);
    for (int t = 0; t < 3; t++) begin
      #1;
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: req_ready=%b, required 00", t, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_data !== 32'h0FA5_A50F
          || rsp_id !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%0b data=%h id=%0d, required 1 0fa5a50f 1",
                 t, rsp_valid, rsp_data, rsp_id);
      end
    end
    idle();
    set_req(0, 1'b1, 32'h0000_00FF, 5'd4, 1'b0);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_release_ready: req_ready=%b, required 01", req_ready);
    end
    tick();
    idle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0FF0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL bp_replace: valid=%0b data=%h id=%0d, required 1 00000ff0 0",
               rsp_valid, rsp_data, rsp_id);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: rsp_valid=%0b, required 0", rsp_valid);
    end
  endtask

  task automatic test_random();
    bit hold [NREQ];
    int bad = 0;
    for (int i = 0; i < NREQ; i++) hold[i] = 0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hold[i])
          set_req(i, 1'($urandom_range(0, 2) != 0), $urandom, 5'($urandom), 1'($urandom));
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      predict();
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand_ready[%0d]: req_ready=%b, required %b", t, req_ready, exp_ready);
      end
      for (int i = 0; i < NREQ; i++) hold[i] = req_valid[i] && !exp_ready[i];
      tick();
      checks++;
      if (rsp_valid !== m_valid || (m_valid && (rsp_data !== m_data || int'(rsp_id) != m_id))
          || done_cnt !== m_cnt) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand_rsp[%0d]: v=%0b d=%h id=%0d cnt=%0d, required %0b %h %0d %0d",
                   t, rsp_valid, rsp_data, rsp_id, done_cnt, m_valid, m_data, m_id, m_cnt);
      end
    end
    idle();
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'h1111_2222, 5'd3, 1'b0);
    #1;
    tick();
    idle();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup: rsp_valid=%0b, required 1", rsp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || done_cnt !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL arst_clear: valid=%0b cnt=%0d data=%h, required 0 0 0",
               rsp_valid, done_cnt, rsp_data);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'h0000_0001, 5'd1, 1'b0);
    set_req(1, 1'b1, 32'h0000_0001, 5'd2, 1'b0);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL arst_ptr: req_ready=%b, required 01", req_ready);
    end
    tick();
    idle();
    checks++;
    if (rsp_id !== 1'b0 || rsp_data !== 32'h0000_0002 || done_cnt !== 16'd1) begin
      errors++;
      $display("FAIL arst_grant: id=%0d data=%h cnt=%0d, required 0 00000002 1",
               rsp_id, rsp_data, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
